// File: rtl/tetris_pkg.sv
// Shared types and constants for the playfield stack.
package tetris_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        SCAN,
        SHIFT,
        DONE
    } stack_state_t;

    localparam int unsigned EMPTY_COLOR = '0;
    localparam int          LINES_W     = 16;

endpackage

// File: rtl/stack_scan_ctrl.sv
// Lock/scan/collapse sequencer: FSM, row counters and line counters.
// Drives write controls into the storage arrays held by the top.
module stack_scan_ctrl
    import tetris_pkg::*;
#(
    parameter  int ROWS = 20,
    localparam int Y_W  = $clog2(ROWS)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               lock_valid,
    input  logic               row_full,
    input  logic               row0_busy,
    input  logic               lock_conflict,
    output logic               lock_ready,
    output logic               accept,
    output logic               lock_we,
    output logic               shift_we,
    output logic [Y_W-1:0]     scan_row,
    output logic [Y_W-1:0]     shift_row,
    output logic               clear_done,
    output logic [2:0]         lines_cleared,
    output logic [LINES_W-1:0] total_lines,
    output logic               game_over
);

    stack_state_t     state;
    logic [2:0]       count;
    logic [LINES_W:0] sum;

    assign accept   = (state == IDLE) && lock_valid && lock_ready;
    assign lock_we  = (state == LOCK);
    assign shift_we = (state == SHIFT);

    // Saturating running total including the lines of the current lock.
    always_comb begin
        sum = {1'b0, total_lines} + {{(LINES_W - 2){1'b0}}, count};
        if (sum[LINES_W]) begin
            sum = {1'b0, {LINES_W{1'b1}}};
        end
    end

    // Sequencer; clear_done and the line counters are loaded on entry to
    // DONE so they are visible during the DONE cycle itself.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            scan_row      <= '0;
            shift_row     <= '0;
            count         <= '0;
            lock_ready    <= 1'b1;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
            game_over     <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lock_ready <= 1'b0;
                        state      <= LOCK;
                    end
                end
                LOCK: begin
                    if (lock_conflict) begin
                        game_over <= 1'b1;
                    end
                    scan_row <= Y_W'(ROWS - 1);
                    count    <= '0;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        shift_row <= scan_row;
                        state     <= SHIFT;
                    end else if (scan_row == '0) begin
                        clear_done    <= 1'b1;
                        lines_cleared <= count;
                        total_lines   <= sum[LINES_W-1:0];
                        state         <= DONE;
                    end else begin
                        scan_row <= scan_row - 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_row == '0) begin
                        count <= count + 1'b1;
                        state <= SCAN;
                    end else begin
                        shift_row <= shift_row - 1'b1;
                    end
                end
                DONE: begin
                    if (row0_busy) begin
                        game_over <= 1'b1;
                    end
                    lock_ready <= !(game_over || row0_busy);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/playfield_stack.sv
// Locked-piece playfield: occupancy and colour storage, lock writes,
// row collapse and the renderer read port.
module playfield_stack
    import tetris_pkg::*;
#(
    parameter  int COLS    = 10,
    parameter  int ROWS    = 20,
    parameter  int NBLK    = 4,
    parameter  int COLOR_W = 3,
    localparam int X_W     = $clog2(COLS),
    localparam int Y_W     = $clog2(ROWS)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               lock_valid,
    output logic               lock_ready,
    input  logic [X_W-1:0]     blocks_xpos [NBLK],
    input  logic [Y_W-1:0]     blocks_ypos [NBLK],
    input  logic [COLOR_W-1:0] lock_color,
    output logic [COLS-1:0]    field [ROWS],
    input  logic [X_W-1:0]     rd_x,
    input  logic [Y_W-1:0]     rd_y,
    output logic [COLOR_W-1:0] rd_color,
    output logic               clear_done,
    output logic [2:0]         lines_cleared,
    output logic [LINES_W-1:0] total_lines,
    output logic               game_over
);

    logic [COLOR_W-1:0] color_mem [ROWS][COLS];
    logic [X_W-1:0]     lock_x [NBLK];
    logic [Y_W-1:0]     lock_y [NBLK];
    logic [COLOR_W-1:0] lock_col;
    logic [NBLK-1:0]    in_range;
    logic               accept, lock_we, shift_we;
    logic               row_full, row0_busy, lock_conflict;
    logic [Y_W-1:0]     scan_row, shift_row;

    stack_scan_ctrl #(.ROWS(ROWS)) u_ctrl (
        .Clk           (Clk),
        .Reset         (Reset),
        .lock_valid    (lock_valid),
        .row_full      (row_full),
        .row0_busy     (row0_busy),
        .lock_conflict (lock_conflict),
        .lock_ready    (lock_ready),
        .accept        (accept),
        .lock_we       (lock_we),
        .shift_we      (shift_we),
        .scan_row      (scan_row),
        .shift_row     (shift_row),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .game_over     (game_over)
    );

    // Row status and collision check against the pre-lock occupancy.
    always_comb begin
        row_full      = &field[scan_row];
        row0_busy     = |field[0];
        lock_conflict = 1'b0;
        for (int unsigned i = 0; i < NBLK; i++) begin
            in_range[i] = (int'(lock_x[i]) < COLS) && (int'(lock_y[i]) < ROWS);
            if (in_range[i] && field[lock_y[i]][lock_x[i]]) begin
                lock_conflict = 1'b1;
            end
        end
    end

    // Capture the piece on the accepting handshake.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NBLK; i++) begin
                lock_x[i] <= '0;
                lock_y[i] <= '0;
            end
            lock_col <= '0;
        end else if (accept) begin
            lock_x   <= blocks_xpos;
            lock_y   <= blocks_ypos;
            lock_col <= lock_color;
        end
    end

    // Playfield storage: lock writes, one-row-per-cycle collapse, clear of row 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                field[r] <= '0;
                for (int unsigned c = 0; c < COLS; c++) begin
                    color_mem[r][c] <= COLOR_W'(EMPTY_COLOR);
                end
            end
        end else if (lock_we) begin
            for (int unsigned i = 0; i < NBLK; i++) begin
                if (in_range[i]) begin
                    field[lock_y[i]][lock_x[i]]     <= 1'b1;
                    color_mem[lock_y[i]][lock_x[i]] <= lock_col;
                end
            end
        end else if (shift_we) begin
            if (shift_row == '0) begin
                field[0] <= '0;
                for (int unsigned c = 0; c < COLS; c++) begin
                    color_mem[0][c] <= COLOR_W'(EMPTY_COLOR);
                end
            end else begin
                field[shift_row] <= field[shift_row - 1'b1];
                for (int unsigned c = 0; c < COLS; c++) begin
                    color_mem[shift_row][c] <= color_mem[shift_row - 1'b1][c];
                end
            end
        end
    end

    // Registered renderer read; out-of-range addresses read as empty.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_color <= '0;
        end else if ((int'(rd_x) < COLS) && (int'(rd_y) < ROWS)) begin
            rd_color <= color_mem[rd_y][rd_x];
        end else begin
            rd_color <= COLOR_W'(EMPTY_COLOR);
        end
    end

endmodule

// File: tb/tb_playfield_stack.sv
// Directed self-checking bench for playfield_stack at default parameters.
module tb_playfield_stack;

    logic        Clk;
    logic        Reset;
    logic        lock_valid;
    logic        lock_ready;
    logic [3:0]  bx [4];
    logic [4:0]  by [4];
    logic [2:0]  lock_color;
    logic [9:0]  field [20];
    logic [3:0]  rd_x;
    logic [4:0]  rd_y;
    logic [2:0]  rd_color;
    logic        clear_done;
    logic [2:0]  lines_cleared;
    logic [15:0] total_lines;
    logic        game_over;

    int vectors;
    int miscompares;
    int lat;
    int pulses;
    logic [9:0] any_row;

    playfield_stack dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .lock_valid    (lock_valid),
        .lock_ready    (lock_ready),
        .blocks_xpos   (bx),
        .blocks_ypos   (by),
        .lock_color    (lock_color),
        .field         (field),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_color      (rd_color),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .game_over     (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic set_piece(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3,
                             input int col);
        bx[0] = 4'(x0); by[0] = 5'(y0);
        bx[1] = 4'(x1); by[1] = 5'(y1);
        bx[2] = 4'(x2); by[2] = 5'(y2);
        bx[3] = 4'(x3); by[3] = 5'(y3);
        lock_color = 3'(col);
    endtask

    // Present a piece for one edge; returns in the cycle after acceptance.
    task automatic start_lock(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3,
                              input int col);
        set_piece(x0, y0, x1, y1, x2, y2, x3, y3, col);
        lock_valid = 1'b1;
        step(1);
        lock_valid = 1'b0;
    endtask

    // Full lock; lat = cycles from acceptance to clear_done. Returns in DONE.
    task automatic do_lock(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3,
                           input int col, output int l);
        start_lock(x0, y0, x1, y1, x2, y2, x3, y3, col);
        l = 1;
        while (!clear_done && l < 400) begin
            step(1);
            l++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        lock_valid  = 1'b0;
        rd_x        = '0;
        rd_y        = '0;
        set_piece(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        Reset = 1'b0;

        // Reset state
        for (int r = 0; r < 20; r++) chk($sformatf("reset_row%0d", r), field[r], 0);
        chk("reset_ready", lock_ready, 1);
        chk("reset_total", total_lines, 0);
        chk("reset_gameover", game_over, 0);
        chk("reset_done", clear_done, 0);
        chk("reset_lines", lines_cleared, 0);

        // Single lock: I-piece on the bottom row, colour 5
        do_lock(0, 19, 1, 19, 2, 19, 3, 19, 5, lat);
        chk("single_latency", lat, 22);
        chk("single_lines", lines_cleared, 0);
        chk("single_row19", field[19], 10'h00F);
        step(1);
        chk("single_done_pulse", clear_done, 0);
        chk("single_ready_back", lock_ready, 1);
        rd_x = 4'd2; rd_y = 5'd19;
        step(1);
        chk("single_rd_19_2", rd_color, 5);
        rd_x = 4'd5;
        step(1);
        chk("single_rd_19_5", rd_color, 0);
        rd_x = 4'd12;
        step(1);
        chk("single_rd_oob", rd_color, 0);

        // Single clear: row 19 completes, row 18 content drops into row 19
        do_reset();
        do_lock(0, 19, 1, 19, 2, 19, 3, 19, 1, lat);
        step(1);
        do_lock(4, 19, 5, 19, 9, 19, 0, 18, 2, lat);
        chk("prefill_lines", lines_cleared, 0);
        step(1);
        do_lock(6, 19, 7, 19, 8, 19, 1, 18, 3, lat);
        chk("clear1_latency", lat, 43);
        chk("clear1_lines", lines_cleared, 1);
        chk("clear1_total", total_lines, 1);
        chk("clear1_row19", field[19], 10'h003);
        chk("clear1_row18", field[18], 0);
        step(1);
        rd_x = 4'd0; rd_y = 5'd19;
        step(1);
        chk("clear1_rd_19_0", rd_color, 2);
        rd_x = 4'd1;
        step(1);
        chk("clear1_rd_19_1", rd_color, 3);
        rd_x = 4'd6;
        step(1);
        chk("clear1_rd_19_6", rd_color, 0);

        // Four-line clear: columns 0..8 of rows 16..19, then vertical I at x=9
        do_reset();
        for (int x = 0; x < 9; x++) begin
            do_lock(x, 16, x, 17, x, 18, x, 19, 6, lat);
            step(1);
        end
        chk("four_prefill_total", total_lines, 0);
        do_lock(9, 16, 9, 17, 9, 18, 9, 19, 7, lat);
        chk("four_latency", lat, 106);
        chk("four_lines", lines_cleared, 4);
        chk("four_total", total_lines, 4);
        any_row = '0;
        for (int r = 0; r < 20; r++) any_row = any_row | field[r];
        chk("four_field_empty", any_row, 0);
        step(1);
        rd_x = 4'd9; rd_y = 5'd19;
        step(1);
        chk("four_rd_19_9", rd_color, 0);
        do_lock(0, 19, 15, 0, 15, 0, 15, 0, 1, lat);
        chk("accum_lines", lines_cleared, 0);
        chk("accum_total", total_lines, 4);
        step(1);

        // Top-out by collision; duplicate blocks on a fresh cell do not count
        do_reset();
        do_lock(3, 10, 3, 10, 15, 0, 15, 0, 4, lat);
        step(1);
        chk("dup_gameover", game_over, 0);
        chk("dup_ready", lock_ready, 1);
        chk("dup_row10", field[10], 10'h008);
        do_lock(3, 10, 3, 9, 15, 0, 15, 0, 4, lat);
        step(1);
        chk("topout_gameover", game_over, 1);
        chk("topout_ready", lock_ready, 0);
        chk("topout_row9", field[9], 10'h008);
        set_piece(0, 19, 1, 19, 2, 19, 3, 19, 2);
        lock_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (clear_done) pulses++;
        end
        lock_valid = 1'b0;
        chk("topout_ignored_pulses", pulses, 0);
        chk("topout_ignored_row19", field[19], 0);
        chk("topout_still_ready0", lock_ready, 0);
        do_reset();
        chk("topout_reset_gameover", game_over, 0);
        chk("topout_reset_ready", lock_ready, 1);

        // Top-out by a block left in row 0
        do_lock(4, 0, 15, 0, 15, 0, 15, 0, 1, lat);
        chk("row0_lat", lat, 22);
        step(1);
        chk("row0_gameover", game_over, 1);
        chk("row0_ready", lock_ready, 0);
        chk("row0_field", field[0], 10'h010);

        // Reset during SHIFT of a two-line clear
        do_reset();
        for (int x = 0; x < 8; x += 2) begin
            do_lock(x, 18, x, 19, x + 1, 18, x + 1, 19, 3, lat);
            step(1);
        end
        do_lock(8, 18, 8, 19, 15, 0, 15, 0, 3, lat);
        step(1);
        start_lock(9, 18, 9, 19, 15, 0, 15, 0, 3);
        step(4);
        chk("midshift_row19", field[19], 10'h3FF);
        chk("midshift_row18", field[18], 0);
        do_reset();
        any_row = '0;
        for (int r = 0; r < 20; r++) any_row = any_row | field[r];
        chk("midshift_reset_field", any_row, 0);
        chk("midshift_reset_ready", lock_ready, 1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (clear_done) pulses++;
            step(1);
        end
        chk("midshift_no_done", pulses, 0);
        chk("midshift_lines", lines_cleared, 0);
        chk("midshift_total", total_lines, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
